fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage of the pipelined LEGv8 CPU. Owns the program counter and drives the byte address into instruction memory. Captures the returned 32-bit word, with its PC, into the IF/ID pipeline register. Handles ID-stage stall, branch redirect (optional delay slot) and sticky fetch faults.

Parameters:
ADDR_W, 64, PC/address width in bits
INSTR_W, 32, instruction width in bits
MEM_BYTES, 1024, instruction memory size in bytes (power of two, >4)
DELAY_SLOT, 1, 1 = instruction fetched in the redirect cycle is kept; 0 = it is squashed
RESET_PC, 0, PC value loaded on reset (word-aligned)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID contents this cycle
redirect  in  1  ID stage: branch/BL/BR taken, load branch_target
branch_target  in  ADDR_W  redirect destination byte address
imem_addr  out  ADDR_W  byte address to instruction memory (= pc, combinational)
imem_instr  in  INSTR_W  instruction word returned combinationally for imem_addr
ifid_valid  out  1  IF/ID register holds a real instruction
ifid_pc  out  ADDR_W  PC of the instruction in IF/ID
ifid_instr  out  INSTR_W  instruction in IF/ID (NOP_INSTR when invalid)
ifid_pc4  out  ADDR_W  ifid_pc + 4, used as the BL link value
fetch_fault  out  1  sticky: misaligned or out-of-range fetch detected

Behaviour:
- State machine: RUN, FAULT. Reset goes to RUN.
- Reset values: pc=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_pc4=4, ifid_instr=NOP_INSTR, fetch_fault=0, state=RUN.
- reset has priority over every other input on any cycle, including mid-stall and in FAULT.
- imem_addr is pc, combinationally. IF/ID is written at the edge that ends the fetch cycle, so latency is 1 cycle from PC to IF/ID.
- RUN, next-PC priority:
  - stall=1: pc and all IF/ID fields hold. redirect is ignored, because the branch in ID is re-presented after the stall.
  - redirect=1 (no stall): pc <= branch_target. IF/ID gets {pc, imem_instr, valid=1} if DELAY_SLOT=1. If DELAY_SLOT=0, IF/ID gets valid=0, instr=NOP_INSTR, pc=current pc.
  - otherwise: pc <= pc+4; IF/ID <= {pc, imem_instr, valid=1}.
- Fault check each RUN cycle, evaluated on the current pc before any update:
  - bad = pc[1:0]!=0 or pc+3 >= MEM_BYTES (unsigned, full ADDR_W arithmetic, no truncation).
  - If bad and stall=0: state <= FAULT, fetch_fault <= 1, IF/ID <= invalid/NOP, pc holds.
  - If bad and stall=1: hold; the check repeats next cycle.
- redirect to a misaligned branch_target is accepted; it faults on the following cycle.
- FAULT: pc frozen, ifid_valid=0, fetch_fault=1. stall and redirect are ignored. Exit only via reset.
- pc+4 wrap at 2^ADDR_W is not special-cased; the range check catches it first.
- ifid_pc4 is always ifid_pc+4, registered together with ifid_pc.

Decomposition:
- Package cpu_pkg:
  - ADDR_W and INSTR_W localparams.
  - NOP_INSTR = 32'hD503201F.
  - typedef struct packed {logic valid; logic [63:0] pc, pc4; logic [31:0] instr;} ifid_t.
  - typedef enum logic {F_RUN, F_FAULT} fetch_state_e.
- Sub-module ifid_reg: holds one ifid_t, with hold (stall), flush (load NOP/invalid) and load inputs and a synchronous reset. fetch_stage instantiates it and keeps the PC logic and FSM itself.

Test Plan:
- Reset: hold reset 2 cycles with stall=1 and redirect=1 → pc=0, ifid_valid=0, ifid_instr=D503201F, fetch_fault=0. On the first free edge ifid_pc=0, ifid_pc4=4.
- Sequential fetch: 4 free cycles after reset → imem_addr 0,4,8,12. ifid_pc lags imem_addr by exactly 1 cycle and ifid_instr equals mem[ifid_pc/4].
- Stall: assert stall for 3 cycles at pc=8 → imem_addr stays 8 and IF/ID stays {pc=4}. After release the next ifid_pc=8, with no duplicate or skipped word.
- Redirect: at pc=12 pulse redirect with target=40 → next imem_addr=40. ifid_pc=12, valid=1 with DELAY_SLOT=1; valid=0, instr=NOP with DELAY_SLOT=0. Stall+redirect together at pc=12 → pc stays 12.
- Misaligned target: redirect to 0x22 → next cycle imem_addr=0x22. One cycle later fetch_fault=1, ifid_valid=0, pc frozen at 0x22. Further redirects are ignored until reset.
- End of memory with MEM_BYTES=1024: free-run to pc=1020 → fetched normally. pc=1024 → fetch_fault=1 and pc stays at 1024. Reset then returns pc to 0 with fetch_fault=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU types and constants used by the pipeline stages.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] instr;
  } ifid_t;

  typedef enum logic {
    F_RUN,
    F_FAULT
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: holds one fetched instruction with hold, flush and load controls.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_hold,
  input  logic  i_flush,
  input  logic  i_load,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  // Priority: reset, hold, flush, load; with no control asserted the contents persist.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '{valid: 1'b0, pc: 64'd0, pc4: 64'd4, instr: NOP_INSTR};
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_flush) begin
      r_q <= '{valid: 1'b0, pc: i_d.pc, pc4: i_d.pc4, instr: NOP_INSTR};
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: owns the PC, fetches from instruction memory and fills IF/ID.
// Handles ID stall, branch redirect (optional delay slot) and a sticky fetch fault.
module fetch_stage #(
  parameter int unsigned          ADDR_W     = cpu_pkg::ADDR_W,
  parameter int unsigned          INSTR_W    = cpu_pkg::INSTR_W,
  parameter int unsigned          MEM_BYTES  = 1024,
  parameter int unsigned          DELAY_SLOT = 1,
  parameter logic [ADDR_W-1:0]    RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ifid_valid,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic               fetch_fault
);
  import cpu_pkg::*;

  localparam int unsigned END_W = ADDR_W + 1;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [END_W-1:0]    w_pc_last;
  logic                w_bad;
  logic                w_hold;
  logic                w_flush;
  logic                w_load;
  ifid_t               w_ifid_d;
  ifid_t               w_ifid_q;

  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  // Extra bit keeps pc+3 from wrapping past the top of the address space.
  assign w_pc_last = {1'b0, r_pc} + END_W'(3);
  assign w_bad     = (r_pc[1:0] != 2'b00) || (w_pc_last >= END_W'(MEM_BYTES));

  assign w_ifid_d = '{valid: 1'b1, pc: r_pc, pc4: w_pc_plus4, instr: imem_instr};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= F_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold      = 1'b0;
    w_flush     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      F_RUN: begin
        if (stall) begin
          w_hold = 1'b1;
        end else if (w_bad) begin
          w_state_nxt = F_FAULT;
          w_flush     = 1'b1;
        end else if (redirect) begin
          w_pc_nxt = branch_target;
          if (DELAY_SLOT != 0) begin
            w_load = 1'b1;
          end else begin
            w_flush = 1'b1;
          end
        end else begin
          w_pc_nxt = w_pc_plus4;
          w_load   = 1'b1;
        end
      end
      F_FAULT: begin
        w_hold = 1'b1;
      end
      default: begin
        w_state_nxt = F_FAULT;
        w_hold      = 1'b1;
      end
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk     (clk),
    .reset   (reset),
    .i_hold  (w_hold),
    .i_flush (w_flush),
    .i_load  (w_load),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_addr   = r_pc;
  assign ifid_valid  = w_ifid_q.valid;
  assign ifid_pc     = w_ifid_q.pc;
  assign ifid_pc4    = w_ifid_q.pc4;
  assign ifid_instr  = w_ifid_q.instr;
  assign fetch_fault = (r_state == F_FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one instance with delay slot, one squashing.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] branch_target;

  logic [63:0] imem_addr,  imem_addr_ns;
  logic [31:0] imem_instr, imem_instr_ns;
  logic        ifid_valid, ifid_valid_ns;
  logic [63:0] ifid_pc,    ifid_pc_ns;
  logic [31:0] ifid_instr, ifid_instr_ns;
  logic [63:0] ifid_pc4,   ifid_pc4_ns;
  logic        fetch_fault, fetch_fault_ns;

  int n_checks;
  int n_errors;

  // Memory word at byte address a: distinct per address, easy to predict.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA500_0000;
  endfunction

  assign imem_instr    = mem_word(imem_addr);
  assign imem_instr_ns = mem_word(imem_addr_ns);

  fetch_stage #(.MEM_BYTES(1024), .DELAY_SLOT(1), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .fetch_fault(fetch_fault)
  );

  fetch_stage #(.MEM_BYTES(1024), .DELAY_SLOT(0), .RESET_PC(64'd0)) dut_ns (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .branch_target(branch_target), .imem_addr(imem_addr_ns), .imem_instr(imem_instr_ns),
    .ifid_valid(ifid_valid_ns), .ifid_pc(ifid_pc_ns), .ifid_instr(ifid_instr_ns),
    .ifid_pc4(ifid_pc4_ns), .fetch_fault(fetch_fault_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    stall         = 1'b1;
    redirect      = 1'b1;
    branch_target = 64'h80;

    // Reset held two cycles with stall and redirect asserted.
    step(2);
    check("rst_pc",     imem_addr,   64'd0);
    check("rst_valid",  ifid_valid,  64'd0);
    check("rst_instr",  ifid_instr,  64'(NOP));
    check("rst_fault",  fetch_fault, 64'd0);
    check("rst_ifidpc", ifid_pc,     64'd0);
    check("rst_pc4",    ifid_pc4,    64'd4);
    reset    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;

    // Sequential fetch: IF/ID lags the PC by one cycle.
    check("seq_addr0", imem_addr, 64'd0);
    step();
    check("seq_addr1",  imem_addr,  64'd4);
    check("seq_ifpc1",  ifid_pc,    64'd0);
    check("seq_pc4_1",  ifid_pc4,   64'd4);
    check("seq_valid1", ifid_valid, 64'd1);
    check("seq_instr1", ifid_instr, 64'(mem_word(64'd0)));
    step();
    check("seq_addr2", imem_addr, 64'd8);
    check("seq_ifpc2", ifid_pc,   64'd4);

    // Stall three cycles at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr,  64'd8);
      check("stall_ifpc", ifid_pc,    64'd4);
      check("stall_inst", ifid_instr, 64'(mem_word(64'd4)));
    end
    stall = 1'b0;
    step();
    check("unstall_addr",  imem_addr,  64'd12);
    check("unstall_ifpc",  ifid_pc,    64'd8);
    check("unstall_instr", ifid_instr, 64'(mem_word(64'd8)));

    // Stall together with redirect: redirect ignored.
    stall         = 1'b1;
    redirect      = 1'b1;
    branch_target = 64'd40;
    step();
    check("stredir_addr", imem_addr, 64'd12);
    check("stredir_ifpc", ifid_pc,   64'd8);

    // Redirect at pc=12 to 40.
    stall = 1'b0;
    step();
    check("redir_addr",      imem_addr,     64'd40);
    check("redir_ifpc",      ifid_pc,       64'd12);
    check("redir_valid",     ifid_valid,    64'd1);
    check("redir_instr",     ifid_instr,    64'(mem_word(64'd12)));
    check("redir_ns_addr",   imem_addr_ns,  64'd40);
    check("redir_ns_ifpc",   ifid_pc_ns,    64'd12);
    check("redir_ns_valid",  ifid_valid_ns, 64'd0);
    check("redir_ns_instr",  ifid_instr_ns, 64'(NOP));
    redirect = 1'b0;
    step();
    check("post_redir_addr",  imem_addr,     64'd44);
    check("post_redir_ifpc",  ifid_pc,       64'd40);
    check("post_redir_pc4",   ifid_pc4,      64'd44);
    check("post_redir_nsval", ifid_valid_ns, 64'd1);

    // Misaligned redirect target: accepted, faults one cycle later.
    redirect      = 1'b1;
    branch_target = 64'h22;
    step();
    check("mis_addr",   imem_addr,   64'h22);
    check("mis_fault0", fetch_fault, 64'd0);
    check("mis_ifpc",   ifid_pc,     64'd44);
    redirect = 1'b0;
    step();
    check("mis_fault1", fetch_fault, 64'd1);
    check("mis_valid",  ifid_valid,  64'd0);
    check("mis_addr1",  imem_addr,   64'h22);
    redirect      = 1'b1;
    branch_target = 64'd0;
    step(2);
    check("flt_redir_addr",  imem_addr,   64'h22);
    check("flt_redir_fault", fetch_fault, 64'd1);
    check("flt_redir_valid", ifid_valid,  64'd0);
    redirect = 1'b0;
    stall    = 1'b1;
    step();
    check("flt_stall_fault", fetch_fault, 64'd1);
    stall = 1'b0;

    // Reset clears the fault.
    do_reset();
    check("rst2_addr",  imem_addr,   64'd0);
    check("rst2_fault", fetch_fault, 64'd0);
    check("rst2_valid", ifid_valid,  64'd0);

    // Free-run to the end of memory.
    for (int i = 1; i <= 256; i++) begin
      step();
      check("run_addr",  imem_addr,   64'(4 * i));
      check("run_ifpc",  ifid_pc,     64'(4 * (i - 1)));
      check("run_fault", fetch_fault, 64'd0);
    end
    check("end_valid", ifid_valid, 64'd1);
    check("end_instr", ifid_instr, 64'(mem_word(64'd1020)));
    step();
    check("oor_fault", fetch_fault, 64'd1);
    check("oor_addr",  imem_addr,   64'd1024);
    check("oor_valid", ifid_valid,  64'd0);
    step(2);
    check("oor_hold",  imem_addr,   64'd1024);

    do_reset();
    check("rst3_addr",  imem_addr,   64'd0);
    check("rst3_fault", fetch_fault, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
